// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter state encoding,
//               data width and the 2-of-3 majority vote helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // 2-of-3 majority used to vote a bit from three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_os_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_os_if
// Description : Byte hold-register handshake and status of the UART receiver.
//               master = receiver side, slave = consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_os_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rxdata;
    logic                      rxready;
    logic                      rxvalid;
    logic                      rxbusy;
    logic                      frameerror;
    logic                      overrun;

    modport master (
        input  rxready,
        output rxdata,
        output rxvalid,
        output rxbusy,
        output frameerror,
        output overrun
    );

    modport slave (
        output rxready,
        input  rxdata,
        input  rxvalid,
        input  rxbusy,
        input  frameerror,
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for an asynchronous input pin, with a
//               configurable value loaded on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply ripple the pin down the two-stage chain
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchronizer flops, preset to the idle level of the pin
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_os
// Description : Majority-voted UART receiver. Recovers 8-bit frames from rxd,
//               presents bytes on a valid/ready hold register, and pulses
//               frameerror / overrun for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       rxd,
    uart_rx_os_if.master    bus
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_samp0    = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_samp1    = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_vote     = c_cnt_w'(c_half + 1);

    logic rxd_s;

    uart_state_e               state_q, state_d;
    logic [c_cnt_w-1:0]        cnt_q, cnt_d;
    logic [2:0]                bitidx_q, bitidx_d;
    logic                      samp0_q, samp0_d;
    logic                      samp1_q, samp1_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rxdata_q, rxdata_d;
    logic                      rxvalid_q, rxvalid_d;
    logic                      frameerror_q, frameerror_d;
    logic                      overrun_q, overrun_d;

    logic w_vote;
    logic w_at_vote;
    logic w_at_wrap;
    logic w_load;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rxd),
        .o_sync  (rxd_s)
    );

    // Third sample is the live synchronized line, so the vote lands on cnt = H+1
    assign w_vote    = maj3(samp0_q, samp1_q, rxd_s);
    assign w_at_vote = (cnt_q == c_vote);
    assign w_at_wrap = (cnt_q == c_cnt_last);

    // Next-state, bit timing, shift register and hold-register handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitidx_d     = bitidx_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
        shift_d      = shift_q;
        rxdata_d     = rxdata_q;
        rxvalid_d    = rxvalid_q;
        frameerror_d = 1'b0;
        overrun_d    = 1'b0;
        w_load       = 1'b0;

        if (rxvalid_q && bus.rxready) begin
            rxvalid_d = 1'b0;
        end

        if (state_q == START || state_q == DATA || state_q == STOP) begin
            cnt_d = w_at_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == c_samp0) samp0_d = rxd_s;
            if (cnt_q == c_samp1) samp1_d = rxd_s;
        end

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that votes high was a glitch
                if (w_at_vote && w_vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (w_at_wrap) begin
                    state_d  = DATA;
                    bitidx_d = '0;
                end
            end
            DATA: begin
                if (w_at_vote) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[UART_DATA_BITS-2:0], w_vote};
                    end else begin
                        shift_d = {w_vote, shift_q[UART_DATA_BITS-1:1]};
                    end
                end
                if (w_at_wrap) begin
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Decide mid-stop so a back-to-back start edge is not missed
                if (w_at_vote) begin
                    cnt_d = '0;
                    if (w_vote) begin
                        w_load  = 1'b1;
                        state_d = rxd_s ? IDLE : START;
                    end else begin
                        frameerror_d = 1'b1;
                        state_d      = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A simultaneous consume and load keeps valid high without an overrun
        if (w_load) begin
            rxdata_d  = shift_q;
            rxvalid_d = 1'b1;
            overrun_d = rxvalid_q && !bus.rxready;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitidx_q     <= '0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            shift_q      <= '0;
            rxdata_q     <= '0;
            rxvalid_q    <= 1'b0;
            frameerror_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitidx_q     <= bitidx_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            shift_q      <= shift_d;
            rxdata_q     <= rxdata_d;
            rxvalid_q    <= rxvalid_d;
            frameerror_q <= frameerror_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rxdata     = rxdata_q;
    assign bus.rxvalid    = rxvalid_q;
    assign bus.rxbusy     = (state_q != IDLE) && (state_q != WAIT_HIGH);
    assign bus.frameerror = frameerror_q;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire
